dual_sng: RTL and testbench

Dual stochastic number generator that turns two WIDTH-bit binary operands into a pair of 2^WIDTH-bit unipolar bitstreams. It sits directly upstream of the skewed two-input stream synchronizer and drives its in0/in1 inputs. The two streams are drawn from one random source and its bit-reversed image, so they start weakly correlated. Each stream carries exactly its operand's count of ones per run.

---
 rtl/unary_sng_pkg.sv | 44 ++++
 rtl/sng_rng.sv | 76 +++++++
 rtl/dual_sng.sv | 120 ++++++++++++
 tb/tb_dual_sng.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unary_sng_pkg.sv
// unary_sng_pkg
// Shared definitions for the dual stochastic number generator:
//   - sng_state_e : run-control states (IDLE, RUN)
//   - lfsr_taps   : maximal-length Fibonacci tap masks for widths 3..10
//   - bitrev      : reverses the low w bits of a 10-bit value
// The LFSR taps are only consumed when SNG_LFSR_EN is defined.
package unary_sng_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sng_state_e;

    localparam int unsigned MAX_WIDTH = 32'd10;

    // Tap mask over state bits: bit W-1 is the oldest bit and is always tapped,
    // which the zero-state insertion in sng_rng relies on.
    function automatic logic [9:0] lfsr_taps(input int unsigned w);
        logic [9:0] t;
        case (w)
            32'd3:   t = 10'b00_0000_0101;
            32'd4:   t = 10'b00_0000_1001;
            32'd5:   t = 10'b00_0001_0010;
            32'd6:   t = 10'b00_0010_0001;
            32'd7:   t = 10'b00_0100_0001;
            32'd8:   t = 10'b00_1000_1110;
            32'd9:   t = 10'b01_0000_1000;
            32'd10:  t = 10'b10_0000_0100;
            default: t = 10'b00_0000_0000;
        endcase
        return t;
    endfunction

    // Reverse all 10 bits, then shift down so only the low w bits remain reversed.
    function automatic logic [9:0] bitrev(input logic [9:0] v, input int unsigned w);
        logic [9:0] r;
        r = 10'b00_0000_0000;
        for (int i = 0; i < 10; i++) begin
            r[i] = v[9 - i];
        end
        return r >> (MAX_WIDTH - w);
    endfunction

endpackage

// File: rtl/sng_rng.sv
// sng_rng
// WIDTH-bit random source for dual_sng. One full period is 2^WIDTH steps and
// visits every value exactly once.
//   SNG_LFSR_EN defined   : Fibonacci LFSR with zero-state insertion, starts at SEED
//   SNG_LFSR_EN undefined : up-counter starting at 0
// Ports:
//   clk      clock
//   rst_n    asynchronous active-low reset (value returns to its start state)
//   load_i   return to the start state (wins over step_i)
//   step_i   advance one step
//   value_o  current value
module sng_rng
    import unary_sng_pkg::*;
#(
    parameter int unsigned WIDTH = 32'd8,
    parameter int unsigned SEED  = 32'd1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] value_o
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

    logic [WIDTH-1:0] rng_q;
    logic [WIDTH-1:0] rng_d;
    logic [WIDTH-1:0] rng_next_s;

`ifdef SNG_LFSR_EN
    localparam logic [WIDTH-1:0] INIT      = WIDTH'(SEED);
    localparam logic [9:0]       TAPS_FULL = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

    logic feedback_s;

    // Flipping the feedback when all bits but the oldest are zero splices the
    // all-zero state in between 100..0 and 00..01.
    always_comb begin
        feedback_s = (^(rng_q & TAPS)) ^ (rng_q[WIDTH-2:0] == ZERO[WIDTH-2:0]);
        rng_next_s = {rng_q[WIDTH-2:0], feedback_s};
    end
`else
    // The counter always starts at zero; SEED only shapes the LFSR start state.
    localparam logic [WIDTH-1:0] INIT = WIDTH'(SEED) ^ WIDTH'(SEED);

    // Plain up-counter step.
    always_comb begin
        rng_next_s = rng_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
`endif

    // Next value: load has priority over step.
    always_comb begin
        if (load_i) begin
            rng_d = INIT;
        end else if (step_i) begin
            rng_d = rng_next_s;
        end else begin
            rng_d = rng_q;
        end
    end

    // Random source state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rng_q <= INIT;
        end else begin
            rng_q <= rng_d;
        end
    end

    assign value_o = rng_q;

endmodule

// File: rtl/dual_sng.sv
// dual_sng
// Dual stochastic number generator: converts two WIDTH-bit operands into two
// 2^WIDTH-bit unipolar streams with exactly val0 / val1 ones per run. Stream 1
// compares against the bit-reversed random value so the streams are weakly
// correlated. Random source mode is selected by the SNG_LFSR_EN macro
// (LFSR when defined, counter/thermometer when undefined).
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   en            advance enable; low freezes the run and drops valid
//   start         load request, taken when start & ready at a rising edge
//   val0, val1    operands (unsigned, WIDTH bits)
//   ready         a start would be accepted this cycle
//   valid         out0/out1 carry a stream bit this cycle
//   out0, out1    stream bits
//   last          final bit of the current run
module dual_sng
    import unary_sng_pkg::*;
#(
    parameter int unsigned WIDTH = 32'd8,
    parameter int unsigned SEED  = 32'd1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] val0,
    input  logic [WIDTH-1:0] val1,
    output logic             ready,
    output logic             valid,
    output logic             out0,
    output logic             out1,
    output logic             last
);

    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_LAST = {WIDTH{1'b1}};

    sng_state_e       state_q, state_d;
    logic [WIDTH-1:0] v0_q, v0_d;
    logic [WIDTH-1:0] v1_q, v1_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] rng_s;
    logic [9:0]       rng_rev_full_s;
    logic [WIDTH-1:0] rng_rev_s;
    logic             valid_s;
    logic             last_s;
    logic             ready_s;
    logic             accept_s;

    // The random source steps on every valid cycle; an accepted start reloads it,
    // which also covers the back-to-back reload on the last bit.
    sng_rng #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_rng (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (accept_s),
        .step_i  (valid_s),
        .value_o (rng_s)
    );

    assign rng_rev_full_s = bitrev(10'(rng_s), WIDTH);
    assign rng_rev_s      = rng_rev_full_s[WIDTH-1:0];

    // Handshake and stream outputs, all derived from registers and en.
    always_comb begin
        valid_s  = (state_q == RUN) & en;
        last_s   = valid_s & (cnt_q == CNT_LAST);
        ready_s  = (state_q == IDLE) | last_s;
        accept_s = start & ready_s;
    end

    // Run control: accept loads operands, each valid cycle counts one bit.
    always_comb begin
        state_d = state_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        cnt_d   = cnt_q;
        if (accept_s) begin
            state_d = RUN;
            v0_d    = val0;
            v1_d    = val1;
            cnt_d   = ZERO;
        end else if (valid_s) begin
            cnt_d = cnt_q + ONE;
            if (last_s) begin
                state_d = IDLE;
            end else begin
                state_d = RUN;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State, operand and bit-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            v0_q    <= ZERO;
            v1_q    <= ZERO;
            cnt_q   <= ZERO;
        end else begin
            state_q <= state_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready = ready_s;
    assign valid = valid_s;
    assign last  = last_s;
    assign out0  = valid_s & (rng_s < v0_q);
    assign out1  = valid_s & (rng_rev_s < v1_q);

endmodule

// File: tb/tb_dual_sng.sv
// tb_dual_sng
// Directed bench for dual_sng at WIDTH=4. A run-level model tracks which bit
// of which run should be on the outputs; a compare process checks every cycle
// and verifies per-run popcounts, with literal expectations for key runs.
module tb_dual_sng;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic       start = 1'b0;
    logic [3:0] val0  = 4'd0;
    logic [3:0] val1  = 4'd0;
    logic       ready, valid, out0, out1, last;

    dual_sng #(.WIDTH(32'd4), .SEED(32'd1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .start (start),
        .val0  (val0),
        .val1  (val1),
        .ready (ready),
        .valid (valid),
        .out0  (out0),
        .out1  (out1),
        .last  (last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // run-level model
    bit m_run   = 1'b0;
    int m_idx   = 0;
    int m_v0    = 0;
    int m_v1    = 0;
    bit new_run = 1'b0;

    logic [15:0] bits0 = 16'h0000, bits1 = 16'h0000;
    logic [15:0] done_s0 = 16'h0000, done_s1 = 16'h0000;
    logic [15:0] ref0 = 16'h0000, ref1 = 16'h0000;
    int run_cycles  = 0;
    int done_cycles = 0;
    int runs_done   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pop16(input logic [15:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 16; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int rev4(input int i);
        logic [3:0] x;
        x = i[3:0];
        return int'({x[0], x[1], x[2], x[3]});
    endfunction

    // Model: which run is active and which bit index it is on.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_run = 1'b0;
                m_idx = 0;
            end else if (start && (!m_run || (en && m_idx == 15))) begin
                m_run   = 1'b1;
                m_idx   = 0;
                m_v0    = int'(val0);
                m_v1    = int'(val1);
                new_run = 1'b1;
            end else if (m_run && en) begin
                if (m_idx == 15) begin
                    m_run = 1'b0;
                    m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
        end
    end

    // Compare process: every cycle away from the active edge.
    initial begin
        bit ev, el, er;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (new_run) begin
                    bits0 = 16'h0000;
                    bits1 = 16'h0000;
                    run_cycles = 0;
                    new_run = 1'b0;
                end
                ev = m_run && en;
                el = ev && (m_idx == 15);
                er = !m_run || el;
                chk("valid", valid, ev);
                chk("ready", ready, er);
                chk("last",  last,  el);
                if (!ev) begin
                    chk("out0_idle", out0, 1'b0);
                    chk("out1_idle", out1, 1'b0);
                end
`ifndef SNG_LFSR_EN
                else begin
                    chk("out0_bit", out0, (m_idx < m_v0));
                    chk("out1_bit", out1, (rev4(m_idx) < m_v1));
                end
`endif
                if (m_run) run_cycles++;
                if (ev) begin
                    bits0 = bits0 | (16'(out0) << m_idx);
                    bits1 = bits1 | (16'(out1) << m_idx);
                    if (el) begin
                        chk("pop0", pop16(bits0), m_v0);
                        chk("pop1", pop16(bits1), m_v1);
                        done_s0     = bits0;
                        done_s1     = bits1;
                        done_cycles = run_cycles;
                        runs_done++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int base);
        int n;
        n = 0;
        while (runs_done == base && n < 200) begin
            tick();
            n++;
        end
        if (runs_done == base) chk("run_timeout", runs_done, base + 1);
    endtask

    task automatic run_one(input int v0, input int v1);
        int base;
        base  = runs_done;
        val0  = 4'(v0);
        val1  = 4'(v1);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(base);
    endtask

    initial begin
        int base;
        int n;

        // reset state
        #3;
        chk("rst_ready", ready, 1'b1);
        chk("rst_valid", valid, 1'b0);
        chk("rst_out0",  out0,  1'b0);
        chk("rst_out1",  out1,  1'b0);
        chk("rst_last",  last,  1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (4) tick();

        // basic run 5 / 11
        run_one(5, 11);
        chk("r1_pop0", pop16(done_s0), 5);
        chk("r1_pop1", pop16(done_s1), 11);
        chk("r1_cycles", done_cycles, 16);
`ifndef SNG_LFSR_EN
        chk("r1_thermo0", done_s0, 16'h001F);
        chk("r1_stream1", done_s1, 16'h5777);
`endif
        ref0 = done_s0;
        ref1 = done_s1;

        // boundary operands
        run_one(0, 15);
        chk("edge_s0_zero", done_s0, 16'h0000);
        chk("edge_pop1", pop16(done_s1), 15);

        // start while not ready is ignored
        base  = runs_done;
        val0  = 4'd5;
        val1  = 4'd11;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        val0  = 4'd9;
        val1  = 4'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(base);
        chk("ign_s0", done_s0, ref0);
        chk("ign_s1", done_s1, ref1);

        // en toggled every other cycle; accept taken with en low
        base  = runs_done;
        en    = 1'b0;
        val0  = 4'd5;
        val1  = 4'd11;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 64 && runs_done == base; c++) begin
            en = (c % 2 == 1);
            tick();
        end
        if (runs_done == base) chk("tog_timeout", runs_done, base + 1);
        en = 1'b1;
        chk("tog_cycles", done_cycles, 32);
        chk("tog_s0", done_s0, ref0);
        chk("tog_s1", done_s1, ref1);

        // back-to-back runs with start held at last
        base  = runs_done;
        val0  = 4'd5;
        val1  = 4'd11;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (m_idx < 12 && n < 50) begin
            tick();
            n++;
        end
        val0  = 4'd3;
        val1  = 4'd7;
        start = 1'b1;
        wait_done(base);
        start = 1'b0;
        #1;
        chk("b2b_nogap", valid, 1'b1);
        wait_done(base + 1);
        chk("b2b_pop0", pop16(done_s0), 3);
        chk("b2b_pop1", pop16(done_s1), 7);
        chk("b2b_cycles", done_cycles, 16);
`ifndef SNG_LFSR_EN
        chk("b2b_thermo0", done_s0, 16'h0007);
        chk("b2b_stream1", done_s1, 16'h1555);
`endif

        // reset at bit 6 aborts the run
        val0  = 4'd5;
        val1  = 4'd11;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (m_idx != 6 && n < 50) begin
            tick();
            n++;
        end
        chk("rst_at_bit6", m_idx, 6);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", ready, 1'b1);
        chk("mid_rst_valid", valid, 1'b0);
        chk("mid_rst_last",  last,  1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        run_one(5, 11);
        chk("post_rst_s0", done_s0, ref0);
        chk("post_rst_s1", done_s1, ref1);
        chk("post_rst_cycles", done_cycles, 16);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
